// File: rtl/npc_pkg.sv
// Shared constants, types and immediate helpers for the npc multi-cycle RV32 core.
package npc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [4:0]  REG_A0      = 5'd10;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_REL,
        NPC_JALR
    } npc_sel_e;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/npc_regfile.sv
// General register file: two asynchronous read ports, one synchronous write port, x0 reads as zero.
module npc_regfile
    import npc_pkg::*;
#(
    parameter int NR_GPR = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    // x0 has no storage, so writes to it simply find no matching entry.
    logic [31:0] regs [1:NR_GPR-1];

    // NOTE: the architectural state must be zero after reset, so this array is
    // reset like flops rather than being left as an unreset RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NR_GPR; i++) regs[i] <= '0;
        end else if (we) begin
            for (int i = 1; i < NR_GPR; i++) begin
                if (waddr == 5'(i)) regs[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int i = 1; i < NR_GPR; i++) begin
            if (raddr1 == 5'(i)) rdata1 = regs[i];
            if (raddr2 == 5'(i)) rdata2 = regs[i];
        end
    end

endmodule

// File: rtl/npc_core_mc.sv
// Multi-cycle RV32I-subset core (FETCH/EXEC/MEM/HALT) with valid/ready memory ports.
// Optional retirement trace port enabled by defining NPC_COMMIT_PORT_EN.
module npc_core_mc
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          NR_GPR   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_valid,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        halt,
    output logic        illegal,
    output logic [31:0] halt_code
`ifdef NPC_COMMIT_PORT_EN
    ,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_inst
`endif
);

    localparam logic [5:0] GPR_LIM = 6'(NR_GPR);

    state_e      state;
    logic [31:0] pc;
    logic [31:0] inst;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        legal;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [31:0] imm;
    npc_sel_e    npc_sel;
    logic        is_mem;
    logic        is_store;
    logic        is_ebreak;
    logic [31:0] mem_ea;
    logic [31:0] next_pc;
    logic        reg_fault;
    logic        fault;

    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        mem_done;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        legal     = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        wb_en     = 1'b0;
        wb_data   = '0;
        imm       = '0;
        npc_sel   = NPC_SEQ;
        is_mem    = 1'b0;
        is_store  = 1'b0;
        is_ebreak = 1'b0;
        case (opcode)
            OP_LUI: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                wb_en   = 1'b1;
                wb_data = imm_u(inst);
            end
            OP_AUIPC: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                wb_en   = 1'b1;
                wb_data = pc + imm_u(inst);
            end
            OP_JAL: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                imm     = imm_j(inst);
                npc_sel = NPC_REL;
            end
            OP_JALR: begin
                legal   = (funct3 == F3_JALR);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                wb_en   = 1'b1;
                wb_data = pc + 32'd4;
                imm     = imm_i(inst);
                npc_sel = NPC_JALR;
            end
            OP_BRANCH: begin
                legal   = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_b(inst);
                if ((rs1_val == rs2_val) == (funct3 == F3_BEQ)) npc_sel = NPC_REL;
            end
            OP_IMM: begin
                legal   = (funct3 == F3_ADD);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                wb_en   = 1'b1;
                wb_data = rs1_val + imm_i(inst);
            end
            OP_REG: begin
                legal   = (funct3 == F3_ADD) && ((funct7 == F7_ADD) || (funct7 == F7_SUB));
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wb_en   = 1'b1;
                wb_data = (funct7 == F7_SUB) ? rs1_val - rs2_val : rs1_val + rs2_val;
            end
            OP_LOAD: begin
                legal   = (funct3 == F3_WORD);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm     = imm_i(inst);
                is_mem  = 1'b1;
            end
            OP_STORE: begin
                legal    = (funct3 == F3_WORD);
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                imm      = imm_s(inst);
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            default: begin
                legal     = (inst == INST_EBREAK);
                is_ebreak = (inst == INST_EBREAK);
            end
        endcase
    end

    assign mem_ea = rs1_val + imm;

    always_comb begin
        case (npc_sel)
            NPC_REL:  next_pc = pc + imm;
            NPC_JALR: next_pc = mem_ea & ~32'd1;
            default:  next_pc = pc + 32'd4;
        endcase
    end

    assign reg_fault = (use_rd  && ({1'b0, rd}  >= GPR_LIM)) ||
                       (use_rs1 && ({1'b0, rs1} >= GPR_LIM)) ||
                       (use_rs2 && ({1'b0, rs2} >= GPR_LIM));

    assign fault = !legal || reg_fault ||
                   (is_mem && (mem_ea[1:0] != 2'b00)) ||
                   (next_pc[1:0] != 2'b00);

    assign mem_done = (state == ST_MEM) && dmem_ready;
    assign rf_we    = ((state == ST_EXEC) && wb_en && !fault) || (mem_done && !dmem_we);
    assign rf_wdata = (state == ST_MEM) ? dmem_rdata : wb_data;

    // EBREAK encodes rs1 = x0, so its read port is borrowed to fetch x10 for halt_code.
    npc_regfile #(
        .NR_GPR (NR_GPR)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 ((inst == INST_EBREAK) ? REG_A0 : rs1),
        .rdata1 (rs1_val),
        .raddr2 (rs2),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata)
    );

    // Gated by rst_n so the fetch request drops the instant reset asserts and
    // rises in the very first cycle after release.
    assign imem_valid = rst_n && (state == ST_FETCH);
    assign imem_addr  = pc;
    assign dmem_valid = (state == ST_MEM);

    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            inst       <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= 4'h0;
            halt       <= 1'b0;
            illegal    <= 1'b0;
            halt_code  <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        inst  <= imem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (fault) begin
                        illegal <= 1'b1;
                        state   <= ST_HALT;
                    end else if (is_ebreak) begin
                        halt      <= 1'b1;
                        halt_code <= rs1_val;
                        state     <= ST_HALT;
                    end else if (is_mem) begin
                        dmem_addr  <= mem_ea;
                        dmem_we    <= is_store;
                        dmem_wdata <= is_store ? rs2_val : 32'd0;
                        dmem_wstrb <= is_store ? 4'hF : 4'h0;
                        state      <= ST_MEM;
                    end else begin
                        pc    <= next_pc;
                        state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        pc         <= pc + 32'd4;
                        dmem_we    <= 1'b0;
                        dmem_wstrb <= 4'h0;
                        state      <= ST_FETCH;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

`ifdef NPC_COMMIT_PORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_inst  <= '0;
        end else begin
            commit_valid <= ((state == ST_EXEC) && !fault && !is_mem) || mem_done;
            commit_pc    <= pc;
            commit_inst  <= inst;
        end
    end
`endif

endmodule

// File: doc/npc_core_mc.md
NPC_CORE_MC -- requirements
Module: npc_core_mc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, address of the first instruction fetched after reset.
REQ-002 SHALL have parameter NR_GPR, default 32, number of general registers; legal values are 16 (RV32E) or 32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports imem_valid out 1, imem_addr out 32, imem_ready in 1, imem_rdata in 32; imem_rdata is sampled in the cycle imem_valid&&imem_ready.
REQ-006 SHALL have ports dmem_valid out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_wstrb out 4, dmem_ready in 1, dmem_rdata in 32; transfer completes in the cycle dmem_valid&&dmem_ready.
REQ-007 SHALL have ports halt out 1 (ebreak retired), illegal out 1 (halted on fault), halt_code out 32 (value of x10 at halt).

Function
REQ-008 SHALL execute the subset LUI, AUIPC, JAL, JALR, BEQ, BNE, ADDI, ADD, SUB, LW, SW, EBREAK; every other encoding SHALL be illegal.
REQ-009 SHALL implement states FETCH, EXEC, MEM, HALT; reset state FETCH.
REQ-010 FETCH: imem_valid=1, imem_addr=pc; on handshake latch inst, go EXEC; else stay, addr held stable.
REQ-011 EXEC: decode, compute; non-memory instructions write rd, update pc, go FETCH in the same edge.
REQ-012 EXEC with LW/SW: go MEM with address rs1+imm latched; no register or pc update yet.
REQ-013 MEM: dmem_valid=1, address/data/strobe/we stable until dmem_ready; on handshake LW writes dmem_rdata to rd, pc+=4, go FETCH.
REQ-014 SW SHALL drive dmem_we=1, dmem_wstrb=4'hF, dmem_wdata=rs2; LW drives dmem_we=0, dmem_wstrb=4'h0.
REQ-015 Next pc: pc+4 default; pc+imm for JAL and taken branch; (rs1+imm)&~1 for JALR; JAL/JALR write pc+4 to rd.
REQ-016 Minimum latency: 2 cycles per non-memory instruction, 3 per LW/SW, with zero-wait memories.
REQ-017 Writes to x0 SHALL be discarded; reads of x0 return 0.
REQ-018 Register index >= NR_GPR in any used rs1/rs2/rd field SHALL be illegal.
REQ-019 LW/SW address with [1:0]!=0, or new pc with [1:0]!=0, SHALL be illegal; no memory request, no register write.
REQ-020 EBREAK in EXEC: go HALT, halt=1, halt_code=x10. Illegal in EXEC: go HALT, illegal=1, halt=0.
REQ-021 HALT SHALL be absorbing until reset; imem_valid=dmem_valid=0.
REQ-022 imem_valid and dmem_valid SHALL never be asserted in the same cycle.
REQ-023 All arithmetic is modulo 2^32; wrap-around of pc and addresses is not a fault.

Reset
REQ-024 rst_n low SHALL immediately force state FETCH, pc=RESET_PC, imem_valid/dmem_valid/dmem_we/halt/illegal=0, dmem_wstrb=0, halt_code=0.
REQ-025 All GPRs SHALL reset to 0.
REQ-026 Reset during an outstanding transfer SHALL abandon it; the core SHALL not wait for ready.
REQ-027 First imem_valid SHALL assert in the first clk cycle after rst_n deasserts.

Configuration
REQ-028 Macro NPC_COMMIT_PORT_EN defined: SHALL add outputs commit_valid (1-cycle pulse per retired instruction, incl. EBREAK), commit_pc, commit_inst; undefined: these ports and logic SHALL be absent, all else identical.

Structure
REQ-029 Package npc_pkg SHALL hold opcode/funct constants, the FSM state enum, next-pc select codes and RESET_PC default.
REQ-030 Register file SHALL be sub-module npc_regfile (param NR_GPR, 2 async reads, 1 sync write, x0 hardwired zero).

Verification
REQ-031 Zero-wait memories, program ADDI x10,x0,5; EBREAK -> halt=1, halt_code=5 on cycle 4 after reset release, illegal=0.
REQ-032 imem_ready held low 3 cycles -> imem_addr stable 32'h8000_0000, no state change; instruction completes 3 cycles later than zero-wait.
REQ-033 SW x5(=32'hDEAD_BEEF) to 0x8000_0100 then LW x6 -> dmem_wstrb=4'hF, dmem_wdata=32'hDEAD_BEEF; x6 reads 32'hDEAD_BEEF.
REQ-034 LW from 0x8000_0102 -> illegal=1, no dmem_valid; NR_GPR=16 with ADDI x20 -> illegal=1.
REQ-035 JALR x1, x2(=0x8000_0011), 0 -> next imem_addr 0x8000_0010, x1=pc+4; BNE not taken -> pc+4.
REQ-036 rst_n pulsed low during dmem_valid wait -> dmem_valid drops same cycle, refetch from RESET_PC; with NPC_COMMIT_PORT_EN, one commit_valid per retired instruction.
